// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit register-file processor control unit.
// Contents:
//   IR_W, NREG            instruction width and general register count
//   *_MSB / *_LSB         instruction field positions: opcode [8:6], X [5:3], Y [2:0]
//   opcode_t              defined opcodes; encodings 100..111 decode as NOP
//   state_t               control time steps T0..T3
//   is_alu()              true for the two ALU opcodes (add, sub)
package proc_pkg;

  localparam int IR_W    = 9;
  localparam int NREG    = 8;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int X_MSB   = 5;
  localparam int X_LSB   = 3;
  localparam int Y_MSB   = 2;
  localparam int Y_LSB   = 0;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  function automatic logic is_alu(input opcode_t opc);
    return (opc == OP_ADD) || (opc == OP_SUB);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable.
// Ports:
//   en      in   1  when low, every output bit is 0
//   sel     in   3  index of the bit to set
//   onehot  out  8  one-hot decode of sel, gated by en
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control unit for the 9-bit register-file processor.  Latches an instruction
// from din into an internal IR during T0 and sequences it over T1..T3, driving
// the bus multiplexer selects and the register / accumulator / ALU enables.
// Ports:
//   clk      in   1     system clock, rising edge
//   reset    in   1     asynchronous active-high; forces T0 and clears IR
//   run      in   1     start request, sampled only in T0
//   din      in   IR_W  instruction word (also the immediate for mvi in T1)
//   ir_in    out  1     IR load enable
//   r_out    out  NREG  one-hot bus select of R0..R7
//   din_out  out  1     bus select: DIN
//   g_out    out  1     bus select: G
//   r_in     out  NREG  register write enables from BUS
//   a_in     out  1     A register load from BUS
//   g_in     out  1     G register load from ALU
//   add_sub  out  1     ALU op: 0 = add, 1 = subtract
//   done     out  1     instruction complete, one-cycle pulse
module proc_ctrl_fsm
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [IR_W-1:0] din,
  output logic            ir_in,
  output logic [NREG-1:0] r_out,
  output logic            din_out,
  output logic            g_out,
  output logic [NREG-1:0] r_in,
  output logic            a_in,
  output logic            g_in,
  output logic            add_sub,
  output logic            done
);

  state_t          state, state_next;
  logic [IR_W-1:0] ir;
  opcode_t         opc;
  logic [2:0]      x_sel, y_sel;

  // Field-level requests from the FSM; the decoders turn them into one-hot.
  logic            x_to_bus, y_to_bus, x_load;
  logic [NREG-1:0] x_onehot, y_onehot;

  assign opc   = opcode_t'(ir[OPC_MSB:OPC_LSB]);
  assign x_sel = ir[X_MSB:X_LSB];
  assign y_sel = ir[Y_MSB:Y_LSB];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks evaluate in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  // IR only moves when an instruction is accepted in T0; din activity during
  // T1..T3 (e.g. the mvi immediate) never disturbs the decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   ir <= '0;
    else if (state == T0 && run) ir <= din;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ir_in      = 1'b0;
    din_out    = 1'b0;
    g_out      = 1'b0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    add_sub    = 1'b0;
    done       = 1'b0;
    x_to_bus   = 1'b0;
    y_to_bus   = 1'b0;
    x_load     = 1'b0;

    case (state)
      T0: begin
        // State is already T0 while reset is high, so run is the only input
        // that could leak through; mask it to keep every output low in reset.
        ir_in = run & ~reset;
        if (run) state_next = T1;
      end

      T1: begin
        case (opc)
          OP_MV: begin
            y_to_bus   = 1'b1;
            x_load     = 1'b1;
            done       = 1'b1;
            state_next = T0;
          end
          OP_MVI: begin
            din_out    = 1'b1;
            x_load     = 1'b1;
            done       = 1'b1;
            state_next = T0;
          end
          OP_ADD, OP_SUB: begin
            x_to_bus   = 1'b1;
            a_in       = 1'b1;
            state_next = T2;
          end
          default: begin
            done       = 1'b1;
            state_next = T0;
          end
        endcase
      end

      T2: begin
        if (is_alu(opc)) begin
          y_to_bus   = 1'b1;
          g_in       = 1'b1;
          add_sub    = ir[OPC_LSB];
          state_next = T3;
        end else begin
          state_next = T0;
        end
      end

      T3: begin
        if (is_alu(opc)) begin
          g_out  = 1'b1;
          x_load = 1'b1;
          done   = 1'b1;
        end
        state_next = T0;
      end

      default: state_next = T0;
    endcase
  end

  dec3to8 u_x_dec (
    .en     (x_to_bus | x_load),
    .sel    (x_sel),
    .onehot (x_onehot)
  );

  dec3to8 u_y_dec (
    .en     (y_to_bus),
    .sel    (y_sel),
    .onehot (y_onehot)
  );

  // The X decoder serves both the bus select (T1 of add/sub) and the write
  // enable (mv/mvi/T3), so each use is gated by its own request.
  assign r_out = (x_to_bus ? x_onehot : '0) | y_onehot;
  assign r_in  = x_load ? x_onehot : '0;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
module tb_proc_ctrl_fsm;
  import proc_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [IR_W-1:0] din;
  logic            ir_in;
  logic [NREG-1:0] r_out;
  logic            din_out;
  logic            g_out;
  logic [NREG-1:0] r_in;
  logic            a_in;
  logic            g_in;
  logic            add_sub;
  logic            done;

  typedef struct packed {
    logic       ir_in;
    logic [7:0] r_out;
    logic       din_out;
    logic       g_out;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       add_sub;
    logic       done;
  } outs_t;

  outs_t sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  proc_ctrl_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .ir_in   (ir_in),
    .r_out   (r_out),
    .din_out (din_out),
    .g_out   (g_out),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .add_sub (add_sub),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic i_in, input logic [7:0] ro, input logic dout,
                               input logic gout, input logic [7:0] ri, input logic ai,
                               input logic gi, input logic as, input logic dn);
    outs_t o;
    o = {i_in, ro, dout, gout, ri, ai, gi, as, dn};
    return o;
  endfunction

  function automatic logic [7:0] bit_of(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  // Pops the oldest expectation and compares it with the live outputs, plus
  // the bus-select and add_sub invariants that must hold in every cycle.
  task automatic compare();
    outs_t obs, exp;
    string tag;
    obs = {ir_in, r_out, din_out, g_out, r_in, a_in, g_in, add_sub, done};
    exp = sb_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (ir_in,r_out,din_out,g_out,r_in,a_in,g_in,add_sub,done)",
             tag, obs, exp);
    end
    checks++;
    assert ($countones({r_out, din_out, g_out}) <= 1) else begin
      errors++;
      $error("FAIL %s_bus_onehot: observed selects=%b expected at most one set",
             tag, {r_out, din_out, g_out});
    end
    checks++;
    assert (!(add_sub && !g_in)) else begin
      errors++;
      $error("FAIL %s_add_sub_gate: observed add_sub=%b g_in=%b expected add_sub=0",
             tag, add_sub, g_in);
    end
  endtask

  // One clock step: drive just after the rising edge, check at the falling edge.
  task automatic step(input logic rst_v, input logic run_v, input logic [8:0] din_v,
                      input outs_t exp, input string tag);
    @(posedge clk);
    #1;
    reset = rst_v;
    run   = run_v;
    din   = din_v;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    compare();
  endtask

  // Reference model of a complete instruction from its opcode semantics.
  // During T1..T3, run is driven to hold_run and din to t1_din, which must not
  // disturb the sequence (apart from mvi, where din is the immediate).
  task automatic run_instr(input logic [8:0] instr, input logic [8:0] t1_din,
                           input logic hold_run, input string tag);
    logic [2:0] op, x, y;
    op = instr[8:6];
    x  = instr[5:3];
    y  = instr[2:0];
    step(0, 1, instr, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {tag, "_t0"});
    case (op)
      3'b000: step(0, hold_run, t1_din, mk(0, bit_of(y), 0, 0, bit_of(x), 0, 0, 0, 1), {tag, "_mv_t1"});
      3'b001: step(0, hold_run, t1_din, mk(0, 0, 1, 0, bit_of(x), 0, 0, 0, 1), {tag, "_mvi_t1"});
      3'b010, 3'b011: begin
        step(0, hold_run, t1_din, mk(0, bit_of(x), 0, 0, 0, 1, 0, 0, 0), {tag, "_alu_t1"});
        step(0, hold_run, ~t1_din, mk(0, bit_of(y), 0, 0, 0, 0, 1, op[0], 0), {tag, "_alu_t2"});
        step(0, hold_run, t1_din, mk(0, 0, 0, 1, bit_of(x), 0, 0, 0, 1), {tag, "_alu_t3"});
      end
      default: step(0, hold_run, t1_din, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), {tag, "_nop_t1"});
    endcase
  endtask

  initial begin
    outs_t zero;
    zero  = '0;
    reset = 1'b1;
    run   = 1'b1;
    din   = 9'h1FF;

    // Reset held with run high: every output must stay low.
    #2;
    sb_q.push_back(zero);
    tag_q.push_back("in_reset");
    compare();

    // Idle in T0 for five cycles.
    for (int i = 0; i < 5; i++) step(0, 0, 9'h1C5, zero, "idle");

    // mvi R3 with the immediate on din during T1.
    step(0, 1, 9'b001_011_000, mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mvi_t0");
    step(0, 0, 9'h055,         mk(0, 8'h00, 1, 0, 8'h08, 0, 0, 0, 1), "mvi_t1");
    step(0, 0, 9'h055,         zero,                                  "mvi_back_t0");

    // add R1,R2; run held high and din scrambled during T1..T3 must be ignored.
    step(0, 1, 9'b010_001_010, mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "add_t0");
    step(0, 1, 9'b011_111_111, mk(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0), "add_t1");
    step(0, 1, 9'b000_000_000, mk(0, 8'h04, 0, 0, 8'h00, 0, 1, 0, 0), "add_t2");
    step(0, 0, 9'b001_110_001, mk(0, 8'h00, 0, 1, 8'h02, 0, 0, 0, 1), "add_t3");
    step(0, 0, 9'h000,         zero,                                  "add_back_t0");

    // sub R5,R5 and the other X == Y cases.
    run_instr(9'b011_101_101, 9'h0AA, 0, "sub_r5r5");
    step(0, 0, 9'h000, zero, "sub_back_t0");
    run_instr(9'b000_011_011, 9'h123, 0, "mv_r3r3");
    run_instr(9'b010_010_010, 9'h0F0, 0, "add_r2r2");
    step(0, 0, 9'h000, zero, "x_eq_y_idle");

    // Reset during T2 of an add: outputs drop at once, no done.
    step(0, 1, 9'b010_001_010, mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "rst_add_t0");
    step(0, 0, 9'h000,         mk(0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0), "rst_add_t1");
    step(1, 1, 9'b001_000_000, zero, "rst_in_t2");
    step(1, 1, 9'b001_000_000, zero, "rst_held");
    step(0, 0, 9'b001_000_000, zero, "rst_release_t0");
    step(0, 1, 9'b000_000_111, mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mv_r0r7_t0");
    step(0, 0, 9'h000,         mk(0, 8'h80, 0, 0, 8'h01, 0, 0, 0, 1), "mv_r0r7_t1");
    step(0, 0, 9'h000,         zero,                                  "mv_r0r7_back_t0");

    // run held high: NOP (opcode 111) chained straight into an mv.
    run_instr(9'b111_010_001, 9'b000_000_001, 1, "nop_chain");
    run_instr(9'b000_001_110, 9'h000, 0, "mv_after_nop");
    step(0, 0, 9'h000, zero, "chain_idle");

    // Other undefined opcodes and a few random instructions through the model.
    run_instr(9'b100_001_010, 9'h000, 0, "nop_100");
    for (int i = 0; i < 8; i++) begin
      logic [8:0] instr;
      instr = 9'($urandom_range(0, 511));
      run_instr(instr, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), "rand");
    end
    step(0, 0, 9'h000, zero, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
